alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Sequential front end that drives the combinational ALU from board switches and one push-button. It steps through operand A, operand B and opcode entry, presents registered operands to the ALU, and captures the ALU result and C/N/V/Z flags into hold registers for display. It sits between the debounced board inputs and the ALU/seven-segment path: it produces the ALU's inputs and consumes its outputs.

## Interface
Parameters:
- N, 4, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  system clock. One clock domain.
- rst  in  1  reset. Asynchronous, active-high.
- sw  in  N  data switches. Asynchronous level.
- op_sw  in  4  opcode switches. Asynchronous level.
- btn_next  in  1  advance button. Debounced, asynchronous, active-high.
- btn_clr  in  1  abort/clear button. Debounced, asynchronous, active-high.
- alu_a  out  N  registered operand A to the ALU.
- alu_b  out  N  registered operand B to the ALU.
- alu_op  out  4  registered opcode to the ALU.
- alu_result  in  N  ALU combinational result.
- alu_c, alu_n, alu_v, alu_z  in  1 each  ALU combinational flags.
- res_q  out  N  captured result.
- c_q, n_q, v_q, z_q  out  1 each  captured flags.
- done  out  1  high while a captured result is held.
- err  out  1  sticky "invalid opcode / divide by zero" indication.
- state_o  out  3  current state encoding, for LEDs.

## Operation
- Button conditioning:
  - Each button goes through a 2-FF synchronizer, then a rising-edge detector.
  - This gives one-cycle pulses, press_next and press_clr.
- FSM states: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, HOLD=4.
- WAIT_A, on press_next: alu_a<=sw, clear err, go to WAIT_B.
- WAIT_B, on press_next: alu_b<=sw, go to WAIT_OP.
- WAIT_OP, on press_next:
  - If op_sw ≥ OP_COUNT (13): set err and stay in WAIT_OP.
  - If op_sw==OP_DIV and alu_b==0: set err and stay in WAIT_OP.
  - Otherwise: alu_op<=op_sw, clear err, go to EXEC.
- EXEC is exactly one cycle. The ALU inputs are stable from registers. At the end of the cycle, res_q<=alu_result, {c_q,n_q,v_q,z_q}<=ALU flags, done<=1, go to HOLD.
- HOLD: outputs are frozen. On press_next: done<=0, go to WAIT_A. alu_a, alu_b and alu_op keep their old values until overwritten.
- press_clr in any state:
  - Go to WAIT_A.
  - done<=0 and err<=0.
  - alu_a, alu_b, alu_op, res_q and flags go to 0.
- press_clr and press_next in the same cycle: clr wins and next is ignored.
- err is sticky. It is cleared by a valid opcode entry, by WAIT_A capture, or by clr.
- Switches are sampled only on the capture edge. Switch changes at other times have no effect.
- Holding a button generates exactly one pulse. A new press requires the synchronized level to return to 0.

## Timing
- Reset state: WAIT_A. Every output is 0: alu_a, alu_b, alu_op, res_q, c_q/n_q/v_q/z_q, done, err and state_o. Synchronizer flops are also 0.
- Reset asserted mid-sequence clears everything immediately, asynchronously. The FSM resumes in WAIT_A on the first clk edge after deassertion.
- Button latency:
  - btn_next is first sampled high at edge n.
  - press_next is high during cycle n+1..n+2.
  - The capture and state change take effect at edge n+2.
- Result latency: alu_op registered at edge k, EXEC during k..k+1, res_q/flags/done valid after edge k+1. End-to-end, the opcode press yields done 3 edges after first sampling.
- No combinational path exists from sw, op_sw or alu_result to any output.

## Structure
- Package alu_pkg holds:
  - The opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_NOTA=4, OP_NOTB=5, OP_XOR=6, OP_ASL=7, OP_ASR=8, OP_LSL=9, OP_LSR=10, OP_MUL=11, OP_DIV=12.
  - OP_COUNT=13.
  - The state enum (3-bit, encodings above).
- The ALU mux shares the same package.
- Sub-module btn_edge_sync: 2-FF synchronizer plus rising-edge pulse, async active-high reset. Instantiated twice.

## Test plan
- Reset sequence: assert rst with N=4 → all outputs 0, state_o=0. Release, then sw=4'h3, press; sw=4'h5, press; op_sw=0, press → alu_a=3, alu_b=5, done=1, res_q=8 after 3 edges, z_q=0.
- Invalid opcode: A=2, B=1, op_sw=13, press → err=1, state_o=2. Then op_sw=1, press → err=0, res_q=1, done=1.
- Divide by zero: A=6, B=0, op_sw=12, press → err=1, no EXEC. clr → state_o=0, err=0.
- Simultaneous clr and next during WAIT_B → state_o=0, alu_a=0.
- Held button: btn_next high for 20 cycles in WAIT_A → exactly one capture, state_o=1.
- Async reset asserted in EXEC → outputs 0 without a clk edge, done never asserts.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU and its operand sequencer: opcode
//   encodings, the number of implemented opcodes, the sequencer state
//   encoding and a helper that decides whether an opcode entry is refused.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOTA  = 4'd4;
    localparam logic [3:0] OP_NOTB  = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_ASL   = 4'd7;
    localparam logic [3:0] OP_ASR   = 4'd8;
    localparam logic [3:0] OP_LSL   = 4'd9;
    localparam logic [3:0] OP_LSR   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;

    localparam logic [3:0] OP_COUNT = 4'd13;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        HOLD    = 3'd4
    } seq_state_t;

    // An opcode entry is refused when the opcode is unimplemented or when
    // it would divide by a zero operand B.
    function automatic logic op_rejected(input logic [3:0] op,
                                         input logic       b_is_zero);
        return (op >= OP_COUNT) || ((op == OP_DIV) && b_is_zero);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_edge_sync.sv
// btn_edge_sync
//   Brings an asynchronous, debounced push-button into the clk domain with
//   a two-flop synchronizer and turns each rising edge of the synchronized
//   level into a single-cycle pulse. Holding the button yields one pulse;
//   the synchronized level must return low before another pulse can occur.
//
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-high reset
//     btn    in   raw button level (asynchronous)
//     pulse  out  one-cycle pulse on each synchronized rising edge
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= btn;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // High for the one cycle between the synchronized level rising and its
    // delayed copy catching up.
    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Front end that feeds the combinational ALU from board switches. Operand
//   A, operand B and the opcode are entered one after another with the
//   "next" button, the registered values drive the ALU, and one cycle later
//   the ALU result and flags are captured into hold registers for display.
//   The "clear" button aborts from any state and zeroes everything.
//
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     sw [N]                 data switches (sampled only on capture)
//     op_sw [4]              opcode switches (sampled only on capture)
//     btn_next, btn_clr      debounced buttons (asynchronous)
//     alu_a, alu_b [N]       registered operands to the ALU
//     alu_op [4]             registered opcode to the ALU
//     alu_result [N]         ALU combinational result
//     alu_c/n/v/z            ALU combinational flags
//     res_q [N], c_q..z_q    captured result and flags
//     done                   high while a captured result is held
//     err                    sticky refused-opcode indication
//     state_o [3]            current state encoding for LEDs
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         btn_next,
    input  logic         btn_clr,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_z,
    output logic [N-1:0] res_q,
    output logic         c_q,
    output logic         n_q,
    output logic         v_q,
    output logic         z_q,
    output logic         done,
    output logic         err,
    output logic [2:0]   state_o
);

    logic press_next;
    logic press_clr;

    btn_edge_sync u_sync_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (press_next)
    );

    btn_edge_sync u_sync_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .pulse (press_clr)
    );

    seq_state_t   state;
    seq_state_t   state_next;

    logic [N-1:0] a_next;
    logic [N-1:0] b_next;
    logic [3:0]   op_next;
    logic [N-1:0] res_next;
    logic [3:0]   flags_next;
    logic         done_next;
    logic         err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= WAIT_A;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            res_q  <= '0;
            c_q    <= 1'b0;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            alu_a  <= a_next;
            alu_b  <= b_next;
            alu_op <= op_next;
            res_q  <= res_next;
            {c_q, n_q, v_q, z_q} <= flags_next;
            done   <= done_next;
            err    <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = alu_a;
        b_next     = alu_b;
        op_next    = alu_op;
        res_next   = res_q;
        flags_next = {c_q, n_q, v_q, z_q};
        done_next  = done;
        err_next   = err;

        if (press_clr) begin
            // Clear takes priority over a simultaneous next press.
            state_next = WAIT_A;
            a_next     = '0;
            b_next     = '0;
            op_next    = '0;
            res_next   = '0;
            flags_next = '0;
            done_next  = 1'b0;
            err_next   = 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (press_next) begin
                        a_next     = sw;
                        err_next   = 1'b0;
                        state_next = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (press_next) begin
                        b_next     = sw;
                        state_next = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (press_next) begin
                        if (op_rejected(op_sw, alu_b == '0)) begin
                            err_next = 1'b1;
                        end else begin
                            op_next    = op_sw;
                            err_next   = 1'b0;
                            state_next = EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Operands and opcode have been stable from registers for
                    // the whole cycle, so the ALU output is settled here.
                    res_next   = alu_result;
                    flags_next = {alu_c, alu_n, alu_v, alu_z};
                    done_next  = 1'b1;
                    state_next = HOLD;
                end
                HOLD: begin
                    if (press_next) begin
                        done_next  = 1'b0;
                        state_next = WAIT_A;
                    end
                end
                default: begin
                    state_next = WAIT_A;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] op_sw;
    logic       btn_next;
    logic       btn_clr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_c;
    logic       alu_n;
    logic       alu_v;
    logic       alu_z;
    logic [3:0] res_q;
    logic       c_q;
    logic       n_q;
    logic       v_q;
    logic       z_q;
    logic       done;
    logic       err;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .op_sw      (op_sw),
        .btn_next   (btn_next),
        .btn_clr    (btn_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_n      (alu_n),
        .alu_v      (alu_v),
        .alu_z      (alu_z),
        .res_q      (res_q),
        .c_q        (c_q),
        .n_q        (n_q),
        .v_q        (v_q),
        .z_q        (z_q),
        .done       (done),
        .err        (err),
        .state_o    (state_o)
    );

    // Small ALU stand-in: add/sub/logic ops, enough for the directed vectors.
    logic [4:0] wide;
    always_comb begin
        wide  = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_op)
            4'd0: begin
                wide  = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = wide[4];
                alu_v = (alu_a[3] == alu_b[3]) && (wide[3] != alu_a[3]);
            end
            4'd1: begin
                wide  = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c = wide[4];
                alu_v = (alu_a[3] != alu_b[3]) && (wide[3] != alu_a[3]);
            end
            4'd2: wide = {1'b0, alu_a & alu_b};
            4'd3: wide = {1'b0, alu_a | alu_b};
            4'd6: wide = {1'b0, alu_a ^ alu_b};
            default: wide = '0;
        endcase
        alu_result = wide[3:0];
        alu_n      = wide[3];
        alu_z      = (wide[3:0] == 4'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press_next;
        @(negedge clk) btn_next = 1'b1;
        @(negedge clk) btn_next = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_clr;
        @(negedge clk) btn_clr = 1'b1;
        @(negedge clk) btn_clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        sw       = 4'h0;
        op_sw    = 4'h0;
        btn_next = 1'b0;
        btn_clr  = 1'b0;

        // Reset state
        #12;
        chk("rst_state", state_o, 3'd0);
        chk("rst_a", alu_a, 4'h0);
        chk("rst_b", alu_b, 4'h0);
        chk("rst_op", alu_op, 4'h0);
        chk("rst_res", res_q, 4'h0);
        chk("rst_flags", {c_q, n_q, v_q, z_q}, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // 3 + 5 with exact opcode-to-done latency
        sw = 4'h3;
        press_next;
        chk("t1_state_b", state_o, 3'd1);
        chk("t1_a", alu_a, 4'h3);
        sw = 4'h5;
        press_next;
        chk("t1_state_op", state_o, 3'd2);
        chk("t1_b", alu_b, 4'h5);
        op_sw = 4'd0;
        @(negedge clk) btn_next = 1'b1;
        @(posedge clk);                 // edge n: first sample
        @(negedge clk) btn_next = 1'b0;
        @(posedge clk);                 // n+1
        @(posedge clk);                 // n+2: opcode captured
        #1;
        chk("t1_exec", state_o, 3'd3);
        chk("t1_done_early", done, 1'b0);
        @(posedge clk);                 // n+3: result captured
        #1;
        chk("t1_done", done, 1'b1);
        chk("t1_hold", state_o, 3'd4);
        chk("t1_res", res_q, 4'h8);
        chk("t1_cnvz", {c_q, n_q, v_q, z_q}, 4'b0110);
        sw    = 4'hF;
        op_sw = 4'd2;
        repeat (4) @(negedge clk);
        chk("t1_frozen_res", res_q, 4'h8);
        chk("t1_frozen_done", done, 1'b1);
        press_next;
        chk("t1_back_a", state_o, 3'd0);
        chk("t1_done_clr", done, 1'b0);
        chk("t1_keep_a", alu_a, 4'h3);

        // Invalid opcode then valid SUB
        sw = 4'h2;
        press_next;
        sw = 4'h1;
        press_next;
        op_sw = 4'd13;
        press_next;
        chk("t2_err", err, 1'b1);
        chk("t2_stay", state_o, 3'd2);
        chk("t2_no_done", done, 1'b0);
        op_sw = 4'd1;
        press_next;
        chk("t2_err_clr", err, 1'b0);
        chk("t2_res", res_q, 4'h1);
        chk("t2_done", done, 1'b1);
        chk("t2_z", z_q, 1'b0);
        press_next;

        // Divide by zero refused, then clear
        sw = 4'h6;
        press_next;
        sw = 4'h0;
        press_next;
        op_sw = 4'd12;
        press_next;
        chk("t3_err", err, 1'b1);
        chk("t3_stay", state_o, 3'd2);
        chk("t3_op_kept", alu_op, 4'd1);
        press_clr;
        chk("t3_clr_state", state_o, 3'd0);
        chk("t3_clr_err", err, 1'b0);
        chk("t3_clr_res", res_q, 4'h0);
        chk("t3_clr_op", alu_op, 4'h0);

        // Simultaneous clear and next in WAIT_B
        sw = 4'h7;
        press_next;
        chk("t4_a", alu_a, 4'h7);
        @(negedge clk) begin btn_next = 1'b1; btn_clr = 1'b1; end
        @(negedge clk) begin btn_next = 1'b0; btn_clr = 1'b0; end
        repeat (4) @(negedge clk);
        chk("t4_state", state_o, 3'd0);
        chk("t4_a_clr", alu_a, 4'h0);
        chk("t4_b_clr", alu_b, 4'h0);

        // Held button: one capture only
        sw = 4'h9;
        @(negedge clk) btn_next = 1'b1;
        repeat (6) @(negedge clk);
        sw = 4'hE;
        repeat (14) @(negedge clk);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_state", state_o, 3'd1);
        chk("t5_a", alu_a, 4'h9);

        // Async reset during EXEC
        sw = 4'h2;
        press_next;
        op_sw = 4'd0;
        @(negedge clk) btn_next = 1'b1;
        @(posedge clk);
        @(negedge clk) btn_next = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_exec", state_o, 3'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_state", state_o, 3'd0);
        chk("t6_rst_a", alu_a, 4'h0);
        chk("t6_rst_b", alu_b, 4'h0);
        chk("t6_rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_done", done, 1'b0);
        chk("t6_res", res_q, 4'h0);
        chk("t6_state", state_o, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
